// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALTED sequencing with trap, redirect, halt and stall handling.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirects into traps with a misalign_o pulse.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] HALT_ADDR = XLEN'(248),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o,
  output logic            halted_o,
  output logic [XLEN-1:0] epc_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] epc, epc_next;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc + XLEN'(4);

`ifdef PC_MISALIGN_TRAP_EN
  logic mis, mis_next;
  logic target_misaligned;

  assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
  logic unused_low_bits;

  // Low target bits are discarded when targets are force-aligned.
  assign unused_low_bits = ^redirect_pc_i[1:0];
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    epc_next   = epc;
`ifdef PC_MISALIGN_TRAP_EN
    mis_next   = 1'b0;
`endif
    unique case (state)
      BOOT: begin
        state_next = RUN;
        pc_next    = RESET_VEC;
      end
      RUN: begin
        if (trap_i) begin
          pc_next  = TRAP_VEC;
          epc_next = pc;
        end else if (redirect_i) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (target_misaligned) begin
            pc_next  = TRAP_VEC;
            epc_next = redirect_pc_i;
            mis_next = 1'b1;
          end else begin
            pc_next  = redirect_pc_i;
          end
`else
          pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif
        end else if (pc == HALT_ADDR) begin
          // Halt wins over stall so a stalled halt address still stops the unit.
          state_next = HALTED;
          pc_next    = HALT_ADDR;
        end else if (!stall_i) begin
          pc_next = pc_plus4;
        end
      end
      HALTED: begin
        pc_next = HALT_ADDR;
        if (resume_i) begin
          state_next = RUN;
          pc_next    = RESET_VEC;
        end
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_VEC;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= BOOT;
      pc    <= RESET_VEC;
      epc   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      mis   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
`ifdef PC_MISALIGN_TRAP_EN
      mis   <= mis_next;
`endif
    end
  end

  assign pc_o       = pc;
  assign pc_plus4_o = pc_plus4;
  assign epc_o      = epc;
  assign valid_o    = (state == RUN);
  assign halted_o   = (state == HALTED);
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_o = mis;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random stimulus against a behavioural model.
module tb_pc_unit;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] HALT_ADDR = 32'd248;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam longint unsigned MASK  = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic        valid, halted, misalign;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN(XLEN),
    .RESET_VEC(RESET_VEC),
    .HALT_ADDR(HALT_ADDR),
    .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .stall_i(stall),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .trap_i(trap),
    .resume_i(resume),
    .pc_o(pc),
    .pc_plus4_o(pc_plus4),
    .valid_o(valid),
    .halted_o(halted),
    .epc_o(epc),
    .misalign_o(misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: "booting"/"stopped" flags plus plain integer PC arithmetic.
  bit              m_booting = 1'b1;
  bit              m_stopped = 1'b0;
  bit              m_pulse   = 1'b0;
  longint unsigned m_pc  = 0;
  longint unsigned m_epc = 0;

  task automatic model_edge();
    longint unsigned tgt;
    tgt = longint'(redirect_pc) & MASK;
    m_pulse = 1'b0;
    if (rst) begin
      m_booting = 1'b1;
      m_stopped = 1'b0;
      m_pc      = RESET_VEC;
      m_epc     = 0;
    end else if (m_booting) begin
      m_booting = 1'b0;
      m_pc      = RESET_VEC;
    end else if (m_stopped) begin
      if (resume) begin
        m_stopped = 1'b0;
        m_pc      = RESET_VEC;
      end
    end else if (trap) begin
      m_epc = m_pc;
      m_pc  = TRAP_VEC;
    end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt % 4 != 0) begin
        m_epc   = tgt;
        m_pc    = TRAP_VEC;
        m_pulse = 1'b1;
      end else begin
        m_pc = tgt;
      end
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else if (m_pc == HALT_ADDR) begin
      m_stopped = 1'b1;
    end else if (!stall) begin
      m_pc = (m_pc + 4) & MASK;
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, (m_pc + 4) & MASK);
    check("valid", valid, !m_booting && !m_stopped);
    check("halted", halted, m_stopped);
    check("epc", epc, m_epc);
    check("misalign", misalign, m_pulse);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; trap = 1'b0; resume = 1'b0;
    redirect_pc = '0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect = 1'b1;
    redirect_pc = target;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and boot sequence 0 (BOOT), 0, 4, 8, 12
    rst = 1'b1;
    step();
    check("rst_pc", pc, 64'h0);
    check("rst_valid", valid, 64'h0);
    clear_inputs();
    step(); check("boot_pc0", pc, 64'h0); check("run_valid", valid, 64'h1);
    step(); check("run_pc4", pc, 64'h4);
    step(); check("run_pc8", pc, 64'h8);
    step(); check("run_pc12", pc, 64'hC);
    step(); check("run_pc16", pc, 64'h10);

    // Stall holds, redirect flushes stall
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("stall_hold", pc, 64'h10);
    end
    do_redirect(32'h40);
    check("stall_redirect", pc, 64'h40);
    stall = 1'b0;

    // Trap beats redirect
    do_redirect(32'h24);
    trap = 1'b1;
    do_redirect(32'h80);
    trap = 1'b0;
    check("trap_pc", pc, 64'h100);
    check("trap_epc", epc, 64'h24);

    // Misaligned redirect
    do_redirect(32'h42);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_pc", pc, 64'h100);
    check("mis_epc", epc, 64'h42);
    check("mis_pulse", misalign, 64'h1);
`else
    check("mis_pc", pc, 64'h40);
    check("mis_pulse", misalign, 64'h0);
`endif
    step();
    check("mis_pulse_end", misalign, 64'h0);

    // Halt, ignore redirect/trap/stall while halted, then resume
    do_redirect(32'hF0);
    step(); step();
    check("pre_halt_pc", pc, 64'd248);
    check("pre_halt_valid", valid, 64'h1);
    step();
    check("halt_flag", halted, 64'h1);
    check("halt_valid", valid, 64'h0);
    check("halt_pc", pc, 64'd248);
    trap = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
    step(); step();
    check("halt_ignore_pc", pc, 64'd248);
    check("halt_ignore_flag", halted, 64'h1);
    clear_inputs();
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_pc", pc, 64'h0);
    check("resume_run", valid, 64'h1);

    // Wrap at top of address space
    do_redirect(32'hFFFF_FFFC);
    check("wrap_pre_plus4", pc_plus4, 64'h0);
    step();
    check("wrap_pc", pc, 64'h0);

    // Reset while halted
    do_redirect(32'hF8);
    step();
    check("halt2_flag", halted, 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("halt_rst_pc", pc, 64'h0);
    check("halt_rst_halted", halted, 64'h0);
    check("halt_rst_valid", valid, 64'h0);

    // Random stimulus
    for (int unsigned n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      trap     = ($urandom_range(0, 15) == 0);
      redirect = ($urandom_range(0, 5) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = $urandom;
        1: redirect_pc = $urandom & 32'hFFFF_FFFC;
        2: redirect_pc = 32'hE0 + ($urandom_range(0, 7) * 4);
        default: redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      endcase
      step();
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
